mem_responder: RTL
==================

MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 Parameter DEPTH_WORDS, default 256, number of 32-bit words in the array (power of two).
REQ-002 Parameter WAIT_CYCLES, default 2, extra wait states between accept and response (0..15).
REQ-003 clock  input  1  single clock; all state updates on its rising edge.
REQ-004 resetN  input  1  asynchronous, active-low reset.
REQ-005 reqValid  input  1  initiator presents a request.
REQ-006 reqReady  output  1  responder can accept a request this cycle.
REQ-007 reqWrite  input  1  1 = store, 0 = load.
REQ-008 reqAddr  input  32  byte address.
REQ-009 reqWData  input  32  store data.
REQ-010 reqByteEn  input  4  store byte lanes; bit i enables bits [8i+7:8i].
REQ-011 rspValid  output  1  response is presented.
REQ-012 rspReady  input  1  initiator accepts the response.
REQ-013 rspRData  output  32  load data; 0 for stores and errors.
REQ-014 rspError  output  1  request was misaligned or out of range.

Function
REQ-015 The FSM SHALL have states IDLE, WAIT, RESP; reqReady SHALL be 1 only in IDLE.
REQ-016 A request SHALL be accepted in a cycle where reqValid && reqReady; addr, write, data, and byteEn SHALL be latched on that edge.
REQ-017 After accept: if WAIT_CYCLES == 0, the FSM SHALL go IDLE->RESP; otherwise IDLE->WAIT with counter = WAIT_CYCLES-1.
REQ-018 In WAIT, the counter SHALL decrement each cycle; at 0 the FSM SHALL go to RESP.
REQ-019 rspValid SHALL rise exactly WAIT_CYCLES+1 cycles after the accept edge.
REQ-020 Error SHALL be: latched addr[1:0] != 0, or word index addr[31:2] >= DEPTH_WORDS.
REQ-021 Store without error SHALL commit the enabled bytes on the edge entering RESP; a store with error SHALL modify nothing.
REQ-022 Load without error SHALL capture the array word on the edge entering RESP.
REQ-023 In RESP, rspValid, rspRData, and rspError SHALL hold stable until rspValid && rspReady.
REQ-024 On the handshake edge the FSM SHALL go RESP->IDLE; no new request is accepted in that same cycle.
REQ-025 A store with reqByteEn == 0 SHALL complete with rspError = 0 and no array change.
REQ-026 A load following a store to the same word SHALL return the merged stored data (no stale read).
REQ-027 rspReady held high before RESP SHALL have no effect; reqValid in non-IDLE states SHALL be ignored.
REQ-028 The counter SHALL be 4 bits; WAIT_CYCLES > 15 SHALL be rejected by an elaboration-time assertion.

Reset
REQ-029 While resetN = 0: state = IDLE, reqReady = 1, rspValid = 0, rspRData = 0, rspError = 0, counter = 0.
REQ-030 Reset asserted in WAIT SHALL abort the request; a pending store SHALL NOT be committed.
REQ-031 Array contents SHALL NOT be cleared by reset.
REQ-032 Reset deassertion SHALL take effect synchronously to clock (two-flop release) before the FSM leaves IDLE.

Structure
REQ-033 Package mem_pkg SHALL hold the state enum (IDLE, WAIT, RESP) and the default constants for DEPTH_WORDS and WAIT_CYCLES.
REQ-034 The storage SHALL be one sub-module, memArray: synchronous write with byte enables, combinational read, DEPTH_WORDS x 32.

Verification
REQ-035 Store 0xDEADBEEF to 0x10, byteEn 4'hF, WAIT_CYCLES=2 -> rspValid 3 cycles after accept, rspError 0; load 0x10 -> rspRData 0xDEADBEEF.
REQ-036 Store 0x000000AA to 0x10, byteEn 4'h1 -> load 0x10 returns 0xDEADBEAA.
REQ-037 Load 0x13 (misaligned) and 0x400 with DEPTH_WORDS=256 -> rspError 1, rspRData 0; array unchanged.
REQ-038 rspReady held 0 for 5 cycles in RESP -> rspValid and rspRData stable, reqReady 0; rspReady 1 -> IDLE next cycle.
REQ-039 resetN pulsed low during WAIT of a store to 0x20 -> rspValid 0, reqReady 1; later load 0x20 returns the prior value.
REQ-040 WAIT_CYCLES=0, back-to-back loads with rspReady tied 1 -> one accept every 2 cycles, rspValid 1 cycle after each accept.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared types and default sizing for the memory responder slice.
package mem_pkg;
    localparam int DEPTH_WORDS_DEF = 256;
    localparam int WAIT_CYCLES_DEF = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_e;
endpackage

// File: rtl/mem_responder_mem_array.sv
// Word-addressed storage: synchronous byte-enabled write, combinational read.
module memArray #(
    parameter int DEPTH_WORDS = 256,
    parameter int AW          = 8
) (
    input  logic          clock,
    input  logic          we,
    input  logic [3:0]    be,
    input  logic [AW-1:0] addr,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);
    logic [31:0] mem [DEPTH_WORDS];

    // Contents intentionally have no reset so they survive a responder reset.
    always_ff @(posedge clock) begin
        if (we) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
            end
        end
    end

    assign rdata = mem[addr];
endmodule

// File: rtl/mem_responder.sv
// Single-outstanding memory responder: accept, wait WAIT_CYCLES, then hold the
// response until the initiator takes it.
module mem_responder import mem_pkg::*; #(
    parameter int DEPTH_WORDS = DEPTH_WORDS_DEF,
    parameter int WAIT_CYCLES = WAIT_CYCLES_DEF
) (
    input  logic        clock,
    input  logic        resetN,
    input  logic        reqValid,
    output logic        reqReady,
    input  logic        reqWrite,
    input  logic [31:0] reqAddr,
    input  logic [31:0] reqWData,
    input  logic [3:0]  reqByteEn,
    output logic        rspValid,
    input  logic        rspReady,
    output logic [31:0] rspRData,
    output logic        rspError
);
    localparam int AW        = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam bit ZERO_WAIT = (WAIT_CYCLES == 0);

    generate
        if (WAIT_CYCLES < 0 || WAIT_CYCLES > 15) begin : g_bad_wait
            $fatal(1, "mem_responder: WAIT_CYCLES must be 0..15");
        end
    endgenerate

    logic [1:0]  rst_sync;
    logic        rst_int_n;
    state_e      state;
    logic [3:0]  cnt;
    logic [31:0] lat_addr, lat_wdata;
    logic        lat_write;
    logic [3:0]  lat_be;
    logic        accept, go_resp, mem_we;
    logic        cur_write, cur_err;
    logic [31:0] cur_addr, cur_wdata, mem_rdata;
    logic [3:0]  cur_be;

    // Assert asynchronously, release two clocks later.
    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) rst_sync <= 2'b00;
        else         rst_sync <= {rst_sync[0], 1'b1};
    end
    assign rst_int_n = rst_sync[1];

    // Ready reads 1 during reset but is withheld while the release is in flight.
    assign reqReady = (state == IDLE) && (rst_int_n || !resetN);
    assign rspValid = (state == RESP);
    assign accept   = reqValid && (state == IDLE) && rst_int_n;
    assign go_resp  = (ZERO_WAIT && accept) || (state == WAIT && cnt == 4'd0);

    // With no wait states the array is accessed on the accept edge, so use live inputs.
    assign cur_addr  = (state == IDLE) ? reqAddr   : lat_addr;
    assign cur_write = (state == IDLE) ? reqWrite  : lat_write;
    assign cur_wdata = (state == IDLE) ? reqWData  : lat_wdata;
    assign cur_be    = (state == IDLE) ? reqByteEn : lat_be;
    assign cur_err   = (cur_addr[1:0] != 2'b00) ||
                       ({2'b00, cur_addr[31:2]} >= 32'(DEPTH_WORDS));
    assign mem_we    = go_resp && cur_write && !cur_err;

    memArray #(.DEPTH_WORDS(DEPTH_WORDS), .AW(AW)) u_mem (
        .clock (clock),
        .we    (mem_we),
        .be    (cur_be),
        .addr  (cur_addr[AW+1:2]),
        .wdata (cur_wdata),
        .rdata (mem_rdata)
    );

    always_ff @(posedge clock or negedge rst_int_n) begin
        if (!rst_int_n) begin
            state     <= IDLE;
            cnt       <= 4'd0;
            rspRData  <= 32'd0;
            rspError  <= 1'b0;
            lat_addr  <= 32'd0;
            lat_wdata <= 32'd0;
            lat_write <= 1'b0;
            lat_be    <= 4'd0;
        end else begin
            if (accept) begin
                lat_addr  <= reqAddr;
                lat_wdata <= reqWData;
                lat_write <= reqWrite;
                lat_be    <= reqByteEn;
            end
            if (go_resp) begin
                rspRData <= (cur_write || cur_err) ? 32'd0 : mem_rdata;
                rspError <= cur_err;
            end
            case (state)
                IDLE: if (accept) begin
                    if (ZERO_WAIT) state <= RESP;
                    else begin
                        state <= WAIT;
                        cnt   <= 4'(WAIT_CYCLES - 1);
                    end
                end
                WAIT: if (cnt == 4'd0) state <= RESP;
                      else             cnt   <= cnt - 4'd1;
                RESP: if (rspReady) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule
